// File: rtl/mux_serial_subtractor.sv
// Bit-serial subtractor, LSB first, using 4:1 muxes for the difference and borrow bits.
// Optional signed-overflow flag (ovf port) is built when SERIAL_SUB_OVF_EN is defined.
module mux_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // The counter must also reach WIDTH itself: the final SHIFT cycle commits the result.
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic             abit;
  logic             bbit;
  logic             dbit;
  logic             bnext;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] diff_shifted;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    abit = 1'b0;
    bbit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt == CW'(i)) begin
        abit = a_q[i];
        bbit = b_q[i];
      end
    end
  end

  always_comb begin
    dbit  = borrow;
    bnext = borrow;
    case ({bbit, abit})
      2'b00: begin dbit = borrow;  bnext = borrow; end
      2'b01: begin dbit = ~borrow; bnext = 1'b0;   end
      2'b10: begin dbit = ~borrow; bnext = 1'b1;   end
      2'b11: begin dbit = borrow;  bnext = borrow; end
      default: begin dbit = borrow; bnext = borrow; end
    endcase
  end

  generate
    if (WIDTH == 1) begin : g_w1
      assign diff_shifted = dbit;
    end else begin : g_wn
      assign diff_shifted = {dbit, diff[WIDTH-1:1]};
    end
  endgenerate

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (cnt == CW'(WIDTH));

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_q    <= a;
        b_q    <= b;
        borrow <= 1'b0;
        cnt    <= '0;
        diff   <= '0;
        bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        ovf    <= 1'b0;
`endif
        busy   <= 1'b1;
        state  <= SHIFT;
      end else begin
        case (state)
          SHIFT: begin
            if (last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              bout  <= borrow;
`ifdef SERIAL_SUB_OVF_EN
              ovf   <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
`endif
            end else begin
              borrow <= bnext;
              diff   <= diff_shifted;
              cnt    <= cnt + CW'(1);
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/mux_serial_subtractor.md
MUX_SERIAL_SUBTRACTOR -- requirements
Module: mux_serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits, legal range 1..32.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to subtract; sampled on rising edge.
REQ-005 a  input  WIDTH  minuend; captured on an accepted start.
REQ-006 b  input  WIDTH  subtrahend; captured on an accepted start.
REQ-007 busy  output  1  high while a subtraction is in progress.
REQ-008 done  output  1  single-cycle pulse: result valid.
REQ-009 diff  output  WIDTH  result a-b mod 2^WIDTH; held until the next accepted start.
REQ-010 bout  output  1  final borrow out of the MSB; held with diff.
REQ-011 ovf  output  1  signed overflow flag; present only with SERIAL_SUB_OVF_EN.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-013 IDLE or DONE with start=1: capture a and b, clear the borrow register and bit counter, clear diff/bout/ovf, go to SHIFT.
REQ-014 IDLE with start=0: stay. DONE with start=0: go to IDLE.
REQ-015 SHIFT SHALL process one bit per cycle, LSB first, for exactly WIDTH cycles, then go to DONE.
REQ-016 Per-bit difference SHALL come from a 4:1 mux with sel={b_i,a_i} and inputs (bin, ~bin, ~bin, bin) for sel 00,01,10,11.
REQ-017 Per-bit borrow SHALL come from a 4:1 mux with sel={b_i,a_i} and inputs (bin, 0, 1, bin).
REQ-018 The borrow register SHALL take the new borrow each SHIFT cycle; the difference bit SHALL shift into diff from the MSB end, so diff is correctly aligned after WIDTH shifts.
REQ-019 Latency: if start is accepted at edge k, done SHALL be high for exactly the cycle after edge k+WIDTH+1; diff and bout SHALL be final in that cycle.
REQ-020 busy SHALL be high in SHIFT only; done SHALL be high in DONE only.
REQ-021 start during SHIFT SHALL be ignored, with no effect on operands or result.
REQ-022 start in DONE SHALL be accepted (back-to-back), and done SHALL still pulse for that cycle.
REQ-023 a and b changing after capture SHALL NOT affect the result.
REQ-024 WIDTH=1 SHALL work: one SHIFT cycle, then DONE.

Reset
REQ-025 rst=1 at any edge, including mid-SHIFT, SHALL force IDLE and SHALL abandon any operation in progress.
REQ-026 Reset values: busy=0, done=0, diff=0, bout=0, ovf=0; the borrow register, counter and operand registers SHALL also be 0.
REQ-027 rst SHALL take priority over start on the same edge.

Configuration
REQ-028 Macro SERIAL_SUB_OVF_EN defined: the ovf port and its logic SHALL exist.
REQ-029 With the macro, ovf SHALL be set in DONE to (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]), using the captured operands, and SHALL be held with diff.
REQ-030 Macro undefined: the ovf port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-031 a=0x05, b=0x03, start pulse -> done 9 edges later; diff=0x02, bout=0, ovf=0.
REQ-032 a=0x03, b=0x05 -> diff=0xFE, bout=1, ovf=0; a=0x00, b=0x00 -> diff=0x00, bout=0.
REQ-033 a=0x80, b=0x01 with SERIAL_SUB_OVF_EN -> diff=0x7F, bout=0, ovf=1; the same stimulus without the macro compiles with no ovf port.
REQ-034 start at edge k, start re-pulsed with a=0xFF during SHIFT -> result is that of the original operands; done pulses exactly once.
REQ-035 rst asserted at the 4th SHIFT cycle -> next cycle busy=0, diff=0, no done pulse; a new start then gives the correct result.
REQ-036 Back-to-back: start held high through DONE with new operands -> the second done pulse arrives WIDTH+1 edges after the DONE-cycle edge; random operands checked against a-b mod 256 across 1000 runs.
